// File: rtl/bike_keygen_core.sv
// BIKE-1-style key generator: samples sparse h0/h1 and dense odd-weight g,
// computes f0 = g*h1 and f1 = g*h0 mod (x^R - 1), streams g/f0/f1 serially.
// Also contains prng_lcg, the 64-bit LCG random source paired with the core.

module prng_lcg (
    input  logic        clk,
    input  logic        rst_b,
    input  logic [1:0]  start,
    input  logic [63:0] prng_t_dat,
    output logic        valid,
    output logic [63:0] prng_r_dat
);
    localparam logic [63:0] LCG_MUL = 64'd6364136223846793005;
    localparam logic [63:0] LCG_INC = 64'd1442695040888963407;

    logic [63:0] r_state;
    logic [63:0] r_dat;
    logic        r_valid;
    logic [63:0] w_next;

    assign w_next     = r_state * LCG_MUL + LCG_INC;
    assign valid      = r_valid;
    assign prng_r_dat = r_dat;

    // Command 2 reseeds, command 1 advances; valid pulses the cycle after either
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state <= '0;
            r_dat   <= '0;
            r_valid <= 1'b0;
        end else begin
            case (start)
                2'd2: begin
                    r_state <= prng_t_dat;
                    r_dat   <= prng_t_dat;
                    r_valid <= 1'b1;
                end
                2'd1: begin
                    r_state <= w_next;
                    r_dat   <= w_next;
                    r_valid <= 1'b1;
                end
                default: r_valid <= 1'b0;
            endcase
        end
    end
endmodule

module bike_keygen_core #(
    parameter int R    = 10163,
    parameter int W    = 71,
    parameter int LOGR = 14
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        start,
    output logic [1:0]  rng_start,
    input  logic        rng_valid,
    input  logic [63:0] rng_in,
    output logic        g_out,
    output logic        f0_out,
    output logic        f1_out,
    output logic        out_valid,
    output logic        done
);
    localparam int NWORDS = (R + 63) / 64;
    localparam int WRDW   = $clog2(NWORDS + 1);
    localparam int WCW    = $clog2(W + 1);
    localparam int LOGR1  = LOGR + 1;
    localparam int PADW   = 1 << LOGR;

    localparam logic [LOGR-1:0]  LAST_IDX  = LOGR'(R - 1);
    localparam logic [LOGR:0]    R_LIM     = LOGR1'(R);
    localparam logic [WRDW-1:0]  LAST_WORD = WRDW'(NWORDS - 1);
    localparam logic [WCW-1:0]   W_LAST    = WCW'(W - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SEED = 3'd1;
    localparam logic [2:0] S_H0   = 3'd2;
    localparam logic [2:0] S_H1   = 3'd3;
    localparam logic [2:0] S_G    = 3'd4;
    localparam logic [2:0] S_MUL  = 3'd5;
    localparam logic [2:0] S_OUT  = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]      r_state;
    logic [R-1:0]    r_h0, r_h1, r_g, r_f0, r_f1, r_gr;
    logic            r_pend;
    logic [WCW-1:0]  r_weight;
    logic [WRDW-1:0] r_word;
    logic [LOGR-1:0] r_idx;

    logic [LOGR-1:0] w_pos;
    logic [PADW-1:0] w_h0_pad, w_h1_pad;
    logic            w_ok_h0, w_ok_h1;
    logic [R-1:0]    w_g_fill, w_g_final;
    logic            w_g_par;

    // Candidate position is rejected when out of range or already set; the
    // padded copies keep the lookup legal for positions between R and 2^LOGR
    assign w_pos    = rng_in[LOGR-1:0];
    assign w_h0_pad = PADW'(r_h0);
    assign w_h1_pad = PADW'(r_h1);
    assign w_ok_h0  = ({1'b0, w_pos} < R_LIM) && !w_h0_pad[w_pos];
    assign w_ok_h1  = ({1'b0, w_pos} < R_LIM) && !w_h1_pad[w_pos];

    // Drop the current RNG word into its 64-bit slot of g, discarding bits past R
    always_comb begin
        w_g_fill = r_g;
        for (int j = 0; j < R; j++) begin
            if (WRDW'(j >> 6) == r_word) begin
                w_g_fill[j] = rng_in[j[5:0]];
            end
        end
    end

    assign w_g_par   = ^w_g_fill;
    assign w_g_final = ((r_word == LAST_WORD) && !w_g_par) ?
                       {w_g_fill[R-1:1], ~w_g_fill[0]} : w_g_fill;

    // A request goes out only while none is outstanding, so draws cost 2 cycles
    always_comb begin
        rng_start = 2'd0;
        case (r_state)
            S_SEED:          if (!r_pend) rng_start = 2'd2;
            S_H0, S_H1, S_G: if (!r_pend) rng_start = 2'd1;
            default:         rng_start = 2'd0;
        endcase
    end

    assign out_valid = (r_state == S_OUT);
    assign g_out     = out_valid & r_g[r_idx];
    assign f0_out    = out_valid & r_f0[r_idx];
    assign f1_out    = out_valid & r_f1[r_idx];
    assign done      = (r_state == S_DONE);

    // Main sequencer: seed, sample h0/h1/g, rotate-and-accumulate, stream out
    always_ff @(posedge clk) begin
        if (rst_b) begin
            r_state  <= S_IDLE;
            r_h0     <= '0;
            r_h1     <= '0;
            r_g      <= '0;
            r_f0     <= '0;
            r_f1     <= '0;
            r_gr     <= '0;
            r_pend   <= 1'b0;
            r_weight <= '0;
            r_word   <= '0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_h0     <= '0;
                        r_h1     <= '0;
                        r_g      <= '0;
                        r_f0     <= '0;
                        r_f1     <= '0;
                        r_gr     <= '0;
                        r_pend   <= 1'b0;
                        r_weight <= '0;
                        r_word   <= '0;
                        r_idx    <= '0;
                        r_state  <= S_SEED;
                    end
                end
                S_SEED: begin
                    if (!r_pend) begin
                        r_pend <= 1'b1;
                    end else if (rng_valid) begin
                        r_pend  <= 1'b0;
                        r_state <= S_H0;
                    end
                end
                S_H0: begin
                    if (!r_pend) begin
                        r_pend <= 1'b1;
                    end else if (rng_valid) begin
                        r_pend <= 1'b0;
                        if (w_ok_h0) begin
                            r_h0[w_pos] <= 1'b1;
                            if (r_weight == W_LAST) begin
                                r_weight <= '0;
                                r_state  <= S_H1;
                            end else begin
                                r_weight <= r_weight + WCW'(1);
                            end
                        end
                    end
                end
                S_H1: begin
                    if (!r_pend) begin
                        r_pend <= 1'b1;
                    end else if (rng_valid) begin
                        r_pend <= 1'b0;
                        if (w_ok_h1) begin
                            r_h1[w_pos] <= 1'b1;
                            if (r_weight == W_LAST) begin
                                r_weight <= '0;
                                r_state  <= S_G;
                            end else begin
                                r_weight <= r_weight + WCW'(1);
                            end
                        end
                    end
                end
                S_G: begin
                    if (!r_pend) begin
                        r_pend <= 1'b1;
                    end else if (rng_valid) begin
                        r_pend <= 1'b0;
                        r_g    <= w_g_final;
                        if (r_word == LAST_WORD) begin
                            r_gr    <= w_g_final;
                            r_idx   <= '0;
                            r_state <= S_MUL;
                        end else begin
                            r_word <= r_word + WRDW'(1);
                        end
                    end
                end
                S_MUL: begin
                    if (r_h1[r_idx]) r_f0 <= r_f0 ^ r_gr;
                    if (r_h0[r_idx]) r_f1 <= r_f1 ^ r_gr;
                    r_gr <= {r_gr[R-2:0], r_gr[R-1]};
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_OUT;
                    end else begin
                        r_idx <= r_idx + LOGR'(1);
                    end
                end
                S_OUT: begin
                    if (r_idx == LAST_IDX) begin
                        r_idx   <= '0;
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + LOGR'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bike_keygen_core.sv
// Self-checking bench for bike_keygen_core with small parameters (R=13, W=3).
// A behavioural key-generation model predicts keys and timing from the RNG stream.

module tb_bike_keygen_core;
    localparam int R = 13, W = 3, LOGR = 4;
    localparam int NW = (R + 63) / 64;
    localparam logic [63:0] LCG_A = 64'd6364136223846793005;
    localparam logic [63:0] LCG_C = 64'd1442695040888963407;

    logic clk = 1'b0, rst_b = 1'b1, start = 1'b0;
    logic [1:0] rng_start, lcg_cmd, unit_cmd = 2'd0;
    logic rng_valid, lcg_valid, m_valid = 1'b0;
    logic [63:0] rng_in, lcg_dat, m_data = '0, m_state = '0, seed = '0;
    logic g_out, f0_out, f1_out, out_valid, done;
    logic use_lcg = 1'b1, unit_mode = 1'b0;
    int m_delay = 1, m_cnt = 0;
    logic [63:0] script_q[$];
    logic [63:0] ref_q[$];
    logic [63:0] ref_st;

    int checks = 0, errors = 0;
    logic [R-1:0] exp_h0, exp_h1, exp_g, exp_f0, exp_f1;
    int exp_draws;
    logic [R-1:0] cap_g, cap_f0, cap_f1, gold_g, gold_f0, gold_f1;
    int cap_n, first_out, last_out, done_cnt, done_cyc, zero_viol, cap_fin;

    bike_keygen_core #(.R(R), .W(W), .LOGR(LOGR)) dut (
        .clk(clk), .rst_b(rst_b), .start(start), .rng_start(rng_start),
        .rng_valid(rng_valid), .rng_in(rng_in), .g_out(g_out), .f0_out(f0_out),
        .f1_out(f1_out), .out_valid(out_valid), .done(done)
    );

    prng_lcg u_lcg (
        .clk(clk), .rst_b(rst_b), .start(lcg_cmd), .prng_t_dat(seed),
        .valid(lcg_valid), .prng_r_dat(lcg_dat)
    );

    assign lcg_cmd   = unit_mode ? unit_cmd : (use_lcg ? rng_start : 2'd0);
    assign rng_valid = use_lcg ? lcg_valid : m_valid;
    assign rng_in    = use_lcg ? lcg_dat : m_data;

    always #5 clk = ~clk;

    // Scripted/delayed RNG responder: script values first, then LCG arithmetic
    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (rst_b) begin
            m_cnt <= 0;
        end else if (!use_lcg && (rng_start == 2'd1 || rng_start == 2'd2)) begin
            if (rng_start == 2'd2) begin
                m_state <= seed;
                m_data  <= seed;
            end else if (script_q.size() > 0) begin
                m_data <= script_q.pop_front();
            end else begin
                m_state <= m_state * LCG_A + LCG_C;
                m_data  <= m_state * LCG_A + LCG_C;
            end
            if (m_delay <= 1) m_valid <= 1'b1;
            else m_cnt <= m_delay - 1;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) m_valid <= 1'b1;
        end
    end

    task automatic ref_next(output logic [63:0] v);
        if (ref_q.size() > 0) v = ref_q.pop_front();
        else begin
            ref_st = ref_st * LCG_A + LCG_C;
            v = ref_st;
        end
    endtask

    task automatic build_ref(input logic [63:0] sd);
        logic [63:0] v;
        int p, wt, guard;
        ref_st = sd;
        exp_draws = 0;
        exp_h0 = '0; exp_h1 = '0; exp_g = '0; exp_f0 = '0; exp_f1 = '0;
        for (int h = 0; h < 2; h++) begin
            wt = 0; guard = 0;
            while (wt < W && guard < 10000) begin
                ref_next(v);
                exp_draws++; guard++;
                p = int'(v[LOGR-1:0]);
                if (h == 0 && p < R && !exp_h0[p]) begin exp_h0[p] = 1'b1; wt++; end
                if (h == 1 && p < R && !exp_h1[p]) begin exp_h1[p] = 1'b1; wt++; end
            end
        end
        for (int k = 0; k < NW; k++) begin
            ref_next(v);
            for (int b = 0; b < 64; b++)
                if (64 * k + b < R) exp_g[64 * k + b] = v[b];
        end
        if ((^exp_g) == 1'b0) exp_g[0] = ~exp_g[0];
        for (int i = 0; i < R; i++)
            for (int j = 0; j < R; j++) begin
                if (exp_h1[i] && exp_g[j]) exp_f0[(i + j) % R] = ~exp_f0[(i + j) % R];
                if (exp_h0[i] && exp_g[j]) exp_f1[(i + j) % R] = ~exp_f1[(i + j) % R];
            end
    endtask

    function automatic int exp_first(input int d);
        return 1 + (1 + d) * (1 + exp_draws + NW) + R;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_b = 1'b1;
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
    endtask

    task automatic capture_run(input int hold, input int limit);
        cap_n = 0; first_out = -1; last_out = -1; done_cnt = 0;
        done_cyc = -1; zero_viol = 0; cap_fin = 0;
        cap_g = '0; cap_f0 = '0; cap_f1 = '0;
        start = 1'b1;
        for (int c = 1; c <= limit; c++) begin
            @(negedge clk);
            if (c == hold) start = 1'b0;
            if (out_valid) begin
                if (cap_n < R) begin
                    cap_g[cap_n] = g_out; cap_f0[cap_n] = f0_out; cap_f1[cap_n] = f1_out;
                end
                if (cap_n == 0) first_out = c;
                last_out = c;
                cap_n++;
            end else if (g_out || f0_out || f1_out) zero_viol++;
            if (done) begin
                done_cnt++; done_cyc = c; cap_fin = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_b = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (rng_start !== 2'd0) begin errors++; $display("[TB] FAIL reset_rng_start: got %0d expected 0", rng_start); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
        checks++; if ({g_out, f0_out, f1_out} !== 3'b000) begin errors++; $display("[TB] FAIL reset_serial: got %b expected 000", {g_out, f0_out, f1_out}); end
        checks++; if (lcg_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_lcg_valid: got %b expected 0", lcg_valid); end
        checks++; if (lcg_dat !== 64'd0) begin errors++; $display("[TB] FAIL reset_lcg_dat: got %0h expected 0", lcg_dat); end
        rst_b = 1'b0;
    endtask

    task automatic test_lcg_unit();
        logic [63:0] e1;
        e1 = 64'd1234 * LCG_A + LCG_C;
        unit_mode = 1'b1;
        @(negedge clk); seed = 64'd1234; unit_cmd = 2'd2;
        @(negedge clk); unit_cmd = 2'd1;
        checks++; if (lcg_valid !== 1'b1) begin errors++; $display("[TB] FAIL lcg_seed_valid: got %b expected 1", lcg_valid); end
        checks++; if (lcg_dat !== 64'd1234) begin errors++; $display("[TB] FAIL lcg_seed_dat: got %0d expected 1234", lcg_dat); end
        @(negedge clk); unit_cmd = 2'd0;
        checks++; if (lcg_valid !== 1'b1) begin errors++; $display("[TB] FAIL lcg_next_valid: got %b expected 1", lcg_valid); end
        checks++; if (lcg_dat !== e1) begin errors++; $display("[TB] FAIL lcg_next_dat: got %0h expected %0h", lcg_dat, e1); end
        @(negedge clk); unit_cmd = 2'd3;
        checks++; if (lcg_valid !== 1'b0) begin errors++; $display("[TB] FAIL lcg_valid_pulse: got %b expected 0", lcg_valid); end
        checks++; if (lcg_dat !== e1) begin errors++; $display("[TB] FAIL lcg_hold: got %0h expected %0h", lcg_dat, e1); end
        @(negedge clk); unit_cmd = 2'd0;
        checks++; if (lcg_valid !== 1'b0 || lcg_dat !== e1) begin errors++; $display("[TB] FAIL lcg_cmd3: got valid %b dat %0h expected 0 / %0h", lcg_valid, lcg_dat, e1); end
        unit_mode = 1'b0;
    endtask

    task automatic test_golden();
        do_reset();
        use_lcg = 1'b1; seed = 64'd1234; ref_q.delete();
        build_ref(seed);
        capture_run(1, 800);
        checks++; if (cap_fin !== 1) begin errors++; $display("[TB] FAIL golden_timeout: got no done expected done within 800 cycles"); end
        checks++; if (cap_n !== R) begin errors++; $display("[TB] FAIL golden_out_len: got %0d expected %0d", cap_n, R); end
        checks++; if (done_cyc !== last_out + 1) begin errors++; $display("[TB] FAIL golden_done_cycle: got %0d expected %0d", done_cyc, last_out + 1); end
        checks++; if (first_out !== exp_first(1)) begin errors++; $display("[TB] FAIL golden_first_out: got %0d expected %0d", first_out, exp_first(1)); end
        checks++; if (cap_g !== exp_g) begin errors++; $display("[TB] FAIL golden_g: got %b expected %b", cap_g, exp_g); end
        checks++; if (cap_f0 !== exp_f0) begin errors++; $display("[TB] FAIL golden_f0: got %b expected %b", cap_f0, exp_f0); end
        checks++; if (cap_f1 !== exp_f1) begin errors++; $display("[TB] FAIL golden_f1: got %b expected %b", cap_f1, exp_f1); end
        checks++; if ((^cap_g) !== 1'b1) begin errors++; $display("[TB] FAIL golden_g_parity: got %b expected 1", ^cap_g); end
        checks++; if (zero_viol !== 0) begin errors++; $display("[TB] FAIL golden_idle_zero: got %0d nonzero bits expected 0", zero_viol); end
        checks++; if ($countones(dut.r_h0) !== W || $countones(dut.r_h1) !== W) begin errors++; $display("[TB] FAIL golden_weight: got %0d/%0d expected %0d", $countones(dut.r_h0), $countones(dut.r_h1), W); end
        checks++; if (dut.r_h0 !== exp_h0 || dut.r_h1 !== exp_h1) begin errors++; $display("[TB] FAIL golden_h: got %b/%b expected %b/%b", dut.r_h0, dut.r_h1, exp_h0, exp_h1); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL golden_done_width: got %b expected 0", done); end
        gold_g = cap_g; gold_f0 = cap_f0; gold_f1 = cap_f1;
    endtask

    task automatic test_rejection();
        do_reset();
        use_lcg = 1'b0; m_delay = 1; seed = {$urandom, $urandom};
        script_q = '{64'd15, 64'd2, 64'd2, 64'd5, 64'd9};
        ref_q = script_q;
        build_ref(seed);
        capture_run(1, 800);
        checks++; if (cap_fin !== 1) begin errors++; $display("[TB] FAIL reject_timeout: got no done expected done"); end
        checks++; if (dut.r_h0 !== 13'h0224) begin errors++; $display("[TB] FAIL reject_h0: got %b expected %b", dut.r_h0, 13'h0224); end
        checks++; if (first_out !== exp_first(1)) begin errors++; $display("[TB] FAIL reject_first_out: got %0d expected %0d", first_out, exp_first(1)); end
        checks++; if (cap_f0 !== exp_f0 || cap_f1 !== exp_f1) begin errors++; $display("[TB] FAIL reject_f: got %b/%b expected %b/%b", cap_f0, cap_f1, exp_f0, exp_f1); end
    endtask

    task automatic test_latency();
        do_reset();
        use_lcg = 1'b0; m_delay = 5; seed = 64'd1234;
        script_q.delete(); ref_q.delete();
        build_ref(seed);
        capture_run(1, 2000);
        checks++; if (cap_fin !== 1) begin errors++; $display("[TB] FAIL latency_timeout: got no done expected done"); end
        checks++; if ({cap_g, cap_f0, cap_f1} !== {gold_g, gold_f0, gold_f1}) begin errors++; $display("[TB] FAIL latency_bits: got %b/%b/%b expected %b/%b/%b", cap_g, cap_f0, cap_f1, gold_g, gold_f0, gold_f1); end
        checks++; if (first_out !== exp_first(5)) begin errors++; $display("[TB] FAIL latency_first_out: got %0d expected %0d", first_out, exp_first(5)); end
        checks++; if (done_cyc !== last_out + 1 || cap_n !== R) begin errors++; $display("[TB] FAIL latency_out_shape: got done %0d len %0d expected %0d / %0d", done_cyc, cap_n, last_out + 1, R); end
        m_delay = 1;
    endtask

    task automatic test_start_hold();
        int extra;
        do_reset();
        use_lcg = 1'b1; seed = {$urandom, $urandom}; ref_q.delete();
        build_ref(seed);
        capture_run(4, 800);
        extra = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (out_valid || done || rng_start != 2'd0) extra++;
        end
        checks++; if (cap_fin !== 1 || cap_f0 !== exp_f0) begin errors++; $display("[TB] FAIL hold_run: got fin %0d f0 %b expected 1 / %b", cap_fin, cap_f0, exp_f0); end
        checks++; if (extra !== 0) begin errors++; $display("[TB] FAIL hold_single_run: got %0d active cycles expected 0", extra); end
    endtask

    task automatic test_back_to_back();
        logic [R-1:0] g1, f01, f11;
        int fin1;
        do_reset();
        use_lcg = 1'b1; seed = {$urandom, $urandom}; ref_q.delete();
        build_ref(seed);
        capture_run(100000, 800);
        fin1 = cap_fin; g1 = cap_g; f01 = cap_f0; f11 = cap_f1;
        capture_run(100000, 800);
        checks++; if (fin1 !== 1 || cap_fin !== 1) begin errors++; $display("[TB] FAIL b2b_timeout: got %0d/%0d expected 1/1", fin1, cap_fin); end
        checks++; if ({g1, f01, f11} !== {exp_g, exp_f0, exp_f1}) begin errors++; $display("[TB] FAIL b2b_run1: got %b/%b/%b expected %b/%b/%b", g1, f01, f11, exp_g, exp_f0, exp_f1); end
        checks++; if ({cap_g, cap_f0, cap_f1} !== {exp_g, exp_f0, exp_f1}) begin errors++; $display("[TB] FAIL b2b_run2: got %b/%b/%b expected %b/%b/%b", cap_g, cap_f0, cap_f1, exp_g, exp_f0, exp_f1); end
        checks++; if (first_out !== exp_first(1) + 1) begin errors++; $display("[TB] FAIL b2b_restart: got %0d expected %0d", first_out, exp_first(1) + 1); end
        start = 1'b0;
    endtask

    task automatic test_reset_mid_mul();
        int target, act;
        do_reset();
        use_lcg = 1'b1; seed = {$urandom, $urandom}; ref_q.delete();
        build_ref(seed);
        target = 3 + 2 * exp_draws + 2 * NW + 5;
        start = 1'b1;
        for (int c = 1; c <= target; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst_b = 1'b1;
        @(negedge clk);
        rst_b = 1'b0;
        checks++; if ({out_valid, done, rng_start, g_out, f0_out, f1_out} !== 7'd0) begin errors++; $display("[TB] FAIL midmul_outputs: got %b expected 0", {out_valid, done, rng_start, g_out, f0_out, f1_out}); end
        checks++; if (dut.r_f0 !== '0 || dut.r_g !== '0) begin errors++; $display("[TB] FAIL midmul_cleared: got %b/%b expected 0", dut.r_f0, dut.r_g); end
        act = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (out_valid || done) act++;
        end
        checks++; if (act !== 0) begin errors++; $display("[TB] FAIL midmul_no_done: got %0d active cycles expected 0", act); end
        capture_run(1, 800);
        checks++; if (cap_fin !== 1 || cap_f1 !== exp_f1 || first_out !== exp_first(1)) begin errors++; $display("[TB] FAIL midmul_rerun: got fin %0d f1 %b first %0d expected 1 / %b / %0d", cap_fin, cap_f1, first_out, exp_f1, exp_first(1)); end
    endtask

    task automatic test_random();
        int d;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            use_lcg = 1'b0; d = $urandom_range(1, 4); m_delay = d;
            seed = {$urandom, $urandom}; script_q.delete(); ref_q.delete();
            build_ref(seed);
            capture_run(1, 2000);
            checks++; if ({cap_g, cap_f0, cap_f1} !== {exp_g, exp_f0, exp_f1}) begin errors++; $display("[TB] FAIL random_key_%0d: got %b/%b/%b expected %b/%b/%b", it, cap_g, cap_f0, cap_f1, exp_g, exp_f0, exp_f1); end
            checks++; if (first_out !== exp_first(d) || done_cyc !== last_out + 1) begin errors++; $display("[TB] FAIL random_timing_%0d: got first %0d done %0d expected %0d / %0d", it, first_out, done_cyc, exp_first(d), last_out + 1); end
        end
        m_delay = 1;
    endtask

    // Scenario sequence followed by the one summary line
    initial begin
        test_reset();
        test_lcg_unit();
        test_golden();
        test_rejection();
        test_latency();
        test_start_hold();
        test_back_to_back();
        test_reset_mid_mul();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
